// File: rtl/noc_flit_merger.sv
// noc_flit_merger: packet-atomic round-robin merger of INPUTS flit streams onto one
// registered output flit link. A grant is held from head to tail so packets never interleave.
module noc_flit_merger #(
  parameter int INPUTS     = 4,
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_clear,
  input  logic [INPUTS*CHANNELS-1:0]     i_valid,
  output logic [INPUTS*CHANNELS-1:0]     o_ready,
  input  logic [INPUTS*FLIT_WIDTH-1:0]   i_flit,
  input  logic [INPUTS-1:0]              i_tail,
  output logic [CHANNELS-1:0]            o_valid,
  input  logic [CHANNELS-1:0]            i_ready,
  output logic [FLIT_WIDTH-1:0]          o_flit,
  output logic                           o_tail,
  input  logic [CHANNELS-1:0]            i_vc_available
);

  localparam int PW = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  typedef enum logic [0:0] {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e           state_r;
  lock_state_e           state_n;
  logic [PW-1:0]         owner_r;
  logic [PW-1:0]         owner_n;
  logic [PW-1:0]         rr_ptr_r;
  logic [PW-1:0]         rr_ptr_n;

  logic [CHANNELS-1:0]   vld_a  [INPUTS];
  logic [FLIT_WIDTH-1:0] flit_a [INPUTS];
  logic [INPUTS-1:0]     req_s;
  logic [INPUTS-1:0]     elig_s;
  logic [31:0]           scan_idx_s;
  logic [PW-1:0]         grant_s;
  logic                  grant_ok_s;
  logic [PW-1:0]         grant_inc_s;
  logic [CHANNELS-1:0]   grant_vld_s;
  logic [FLIT_WIDTH-1:0] grant_flit_s;
  logic                  grant_tail_s;
  logic                  out_accept_s;
  logic                  slot_free_s;
  logic                  in_accept_s;
  logic                  locked_s;

  // Unpack the flattened per-input buses into indexable arrays.
  always_comb begin
    for (int p = 0; p < INPUTS; p++) begin
      vld_a[p]  = i_valid[p*CHANNELS +: CHANNELS];
      flit_a[p] = i_flit[p*FLIT_WIDTH +: FLIT_WIDTH];
      req_s[p]  = |i_valid[p*CHANNELS +: CHANNELS];
    end
  end

  // Eligibility: a head needs an available VC; while locked only the owner may continue.
  always_comb begin
    elig_s = '0;
    case (state_r)
      ST_OPEN: begin
        for (int p = 0; p < INPUTS; p++) begin
          elig_s[p] = |(i_valid[p*CHANNELS +: CHANNELS] & i_vc_available);
        end
      end
      ST_LOCKED: begin
        for (int p = 0; p < INPUTS; p++) begin
          elig_s[p] = req_s[p] & (owner_r == PW'(p));
        end
      end
      default: begin
        elig_s = '0;
      end
    endcase
  end

  // Round-robin scan starting at rr_ptr; scanning backwards lets the nearest candidate win.
  always_comb begin
    scan_idx_s = 32'd0;
    grant_s    = rr_ptr_r;
    grant_ok_s = 1'b0;
    for (int k = INPUTS - 1; k >= 0; k--) begin
      scan_idx_s = (32'(rr_ptr_r) + 32'(k)) % 32'(INPUTS);
      if (elig_s[PW'(scan_idx_s)]) begin
        grant_s    = PW'(scan_idx_s);
        grant_ok_s = 1'b1;
      end else begin
        grant_ok_s = grant_ok_s;
      end
    end
  end

  // Select the granted input's flit and compute the pointer value after it.
  always_comb begin
    grant_vld_s  = vld_a[grant_s];
    grant_flit_s = flit_a[grant_s];
    grant_tail_s = i_tail[grant_s];
    if (grant_s == PW'(INPUTS - 1)) begin
      grant_inc_s = '0;
    end else begin
      grant_inc_s = grant_s + PW'(1);
    end
  end

  // One-entry output slot handshake and the replicated per-input ready.
  always_comb begin
    out_accept_s = |(o_valid & i_ready);
    slot_free_s  = (o_valid == '0) | out_accept_s;
    in_accept_s  = grant_ok_s & slot_free_s & ~i_clear & ~rst;
    o_ready      = '0;
    for (int p = 0; p < INPUTS; p++) begin
      o_ready[p*CHANNELS +: CHANNELS] = {CHANNELS{in_accept_s & (grant_s == PW'(p))}};
    end
  end

  // Lock FSM and round-robin pointer next-state; clear releases the lock but keeps the pointer.
  always_comb begin
    state_n  = state_r;
    owner_n  = owner_r;
    rr_ptr_n = rr_ptr_r;
    if (i_clear) begin
      state_n = ST_OPEN;
    end else if (in_accept_s) begin
      if (grant_tail_s) begin
        state_n  = ST_OPEN;
        rr_ptr_n = grant_inc_s;
      end else begin
        state_n = ST_LOCKED;
        owner_n = grant_s;
      end
    end else begin
      state_n = state_r;
    end
  end

  // Lock state, owner and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_OPEN;
      owner_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r  <= state_n;
      owner_r  <= owner_n;
      rr_ptr_r <= rr_ptr_n;
    end
  end

  // Output slot: load on input accept, empty on drain, hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= '0;
      o_flit  <= '0;
      o_tail  <= 1'b0;
    end else if (i_clear) begin
      o_valid <= '0;
    end else if (in_accept_s) begin
      o_valid <= grant_vld_s;
      o_flit  <= grant_flit_s;
      o_tail  <= grant_tail_s;
    end else if (out_accept_s) begin
      o_valid <= '0;
    end
  end

  assign locked_s = (state_r == ST_LOCKED);

  noc_flit_merger_checker #(
    .INPUTS     (INPUTS),
    .CHANNELS   (CHANNELS),
    .FLIT_WIDTH (FLIT_WIDTH)
  ) u_checker (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_flit    (i_flit),
    .locked    (locked_s),
    .in_accept (in_accept_s),
    .grant_vld (grant_vld_s)
  );

endmodule

// noc_flit_merger_checker: interface rules the upstream must obey and packet VC consistency.
module noc_flit_merger_checker #(
  parameter int INPUTS     = 4,
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 32
) (
  input logic                         clk,
  input logic                         rst,
  input logic [INPUTS*CHANNELS-1:0]   i_valid,
  input logic [INPUTS*CHANNELS-1:0]   o_ready,
  input logic [INPUTS*FLIT_WIDTH-1:0] i_flit,
  input logic                         locked,
  input logic                         in_accept,
  input logic [CHANNELS-1:0]          grant_vld
);

  logic [INPUTS-1:0]            hold_r;
  logic [INPUTS*CHANNELS-1:0]   valid_q_r;
  logic [INPUTS*FLIT_WIDTH-1:0] flit_q_r;
  logic [CHANNELS-1:0]          pkt_vc_r;

  // Remember which offers were refused last cycle and the VC of the last accepted flit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r    <= '0;
      valid_q_r <= '0;
      flit_q_r  <= '0;
      pkt_vc_r  <= '0;
    end else begin
      for (int p = 0; p < INPUTS; p++) begin
        hold_r[p] <= (|i_valid[p*CHANNELS +: CHANNELS]) & ~(|o_ready[p*CHANNELS +: CHANNELS]);
      end
      valid_q_r <= i_valid;
      flit_q_r  <= i_flit;
      if (in_accept) begin
        pkt_vc_r <= grant_vld;
      end
    end
  end

  for (genvar p = 0; p < INPUTS; p++) begin : g_in
    a_vc_onehot : assert property (@(posedge clk) disable iff (rst)
      $onehot0(i_valid[p*CHANNELS +: CHANNELS]));
    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
      hold_r[p] |-> ((i_valid[p*CHANNELS +: CHANNELS] == valid_q_r[p*CHANNELS +: CHANNELS]) &&
                     (i_flit[p*FLIT_WIDTH +: FLIT_WIDTH] == flit_q_r[p*FLIT_WIDTH +: FLIT_WIDTH])));
  end

  a_owner_vc : assert property (@(posedge clk) disable iff (rst)
    (locked && in_accept) |-> (grant_vld == pkt_vc_r));

endmodule
